// File: rtl/stopwatch_bcd8.sv
// HH:MM:SS.cc BCD stopwatch with 1 kHz strobe generator for the seven-segment scanner.
// Start/stop, lap-freeze and clear are edge-triggered from debounced button levels.
module stopwatch_bcd8 #(
  parameter  int CLK_HZ  = 50_000_000,
  localparam int PLS_DIV = CLK_HZ / 1000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_btn_ss,
  input  logic        i_btn_lap,
  input  logic        i_btn_clr,
  output logic        o_pls_1k,
  output logic [31:0] o_bcd8d,
  output logic        o_running,
  output logic        o_lap,
  output logic        o_ovf
);

  // state | meaning
  // IDLE  | cleared, not counting
  // RUN   | counting, display live
  // LAP   | counting, display frozen on lap snapshot
  // PAUSE | stopped, display live, div10 phase retained
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] LAP   = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  localparam int PW = (PLS_DIV > 1) ? $clog2(PLS_DIV) : 1;

  logic [PW-1:0] r_psc;
  logic          r_pls_1k;
  logic [3:0]    r_div10;
  logic [1:0]    r_state;
  logic [31:0]   r_cnt;
  logic [31:0]   r_lap;
  logic          r_ovf;
  logic          r_ss_q, r_lap_q, r_clr_q;

  logic          w_ss_e, w_lap_e, w_clr_e;
  logic          w_run, w_tick, w_wrap;
  logic [1:0]    w_state_nxt;
  logic          w_snap, w_clear, w_div_clr;
  logic [31:0]   w_inc, w_cnt_nxt;
  logic          w_carry;

  assign w_ss_e  = i_btn_ss  & ~r_ss_q;
  assign w_lap_e = i_btn_lap & ~r_lap_q;
  assign w_clr_e = i_btn_clr & ~r_clr_q;

  assign w_run  = (r_state == RUN) || (r_state == LAP);
  assign w_tick = w_run && r_pls_1k && (r_div10 == 4'd9);
  assign w_wrap = (r_cnt == 32'h2359_5999);

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_clear     = 1'b0;
    w_div_clr   = 1'b0;
    case (r_state)
      IDLE: if (w_ss_e) begin
        w_state_nxt = RUN;
        w_div_clr   = 1'b1;
      end
      RUN: begin
        if (w_ss_e) w_state_nxt = PAUSE;
        else if (w_lap_e) begin
          w_state_nxt = LAP;
          w_snap      = 1'b1;
        end
      end
      LAP: begin
        if (w_ss_e) w_state_nxt = PAUSE;
        else if (w_lap_e) w_state_nxt = RUN;
      end
      PAUSE: begin
        if (w_clr_e) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
        end else if (w_ss_e) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ripple-carry BCD increment: cc and SS/MM digits, then the 00-23 hour pair.
  always_comb begin
    w_inc   = r_cnt;
    w_carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (w_carry) begin
        if (r_cnt[i*4 +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
          w_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_inc[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
    end
    if (w_carry) begin
      if (r_cnt[31:28] == 4'd2 && r_cnt[27:24] == 4'd3) begin
        w_inc[31:24] = 8'h00;
      end else if (r_cnt[27:24] == 4'd9) begin
        w_inc[27:24] = 4'd0;
        w_inc[31:28] = r_cnt[31:28] + 4'd1;
      end else begin
        w_inc[27:24] = r_cnt[27:24] + 4'd1;
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_clear)     w_cnt_nxt = 32'h0;
    else if (w_tick) w_cnt_nxt = w_inc;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_psc    <= '0;
      r_pls_1k <= 1'b0;
    end else begin
      r_psc    <= (r_psc == PW'(PLS_DIV - 1)) ? '0 : r_psc + PW'(1);
      r_pls_1k <= (r_psc == PW'(PLS_DIV - 1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_div10 <= 4'd0;
      r_cnt   <= 32'h0;
      r_lap   <= 32'h0;
      r_ovf   <= 1'b0;
      r_ss_q  <= 1'b0;
      r_lap_q <= 1'b0;
      r_clr_q <= 1'b0;
    end else begin
      r_ss_q  <= i_btn_ss;
      r_lap_q <= i_btn_lap;
      r_clr_q <= i_btn_clr;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_tick && w_wrap;
      if (w_snap) r_lap <= r_cnt;
      if (w_clear || w_div_clr)  r_div10 <= 4'd0;
      else if (w_run && r_pls_1k) r_div10 <= (r_div10 == 4'd9) ? 4'd0 : r_div10 + 4'd1;
    end
  end

  assign o_pls_1k  = r_pls_1k;
  assign o_running = w_run;
  assign o_lap     = (r_state == LAP);
  assign o_ovf     = r_ovf;
  assign o_bcd8d   = (r_state == LAP) ? r_lap : r_cnt;

endmodule

// File: tb/tb_stopwatch_bcd8.sv
// Bench for stopwatch_bcd8: model tracks elapsed running milliseconds and derives
// the displayed time arithmetically from that, checked inside each scenario task.
module tb_stopwatch_bcd8;

  localparam int          CLK_HZ  = 10_000;
  localparam int          PLS_DIV = CLK_HZ / 1000;
  localparam int unsigned DAY     = 8_640_000;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_btn_ss = 1'b0, i_btn_lap = 1'b0, i_btn_clr = 1'b0;
  logic        o_pls_1k, o_running, o_lap, o_ovf;
  logic [31:0] o_bcd8d;

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 idle, 1 run, 2 lap, 3 pause
  int          m_st;
  int unsigned m_ms, m_snap, m_cyc;
  bit          m_pss, m_plap, m_pclr;
  bit          e_pls, e_ovf;

  stopwatch_bcd8 #(.CLK_HZ(CLK_HZ)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_btn_ss(i_btn_ss), .i_btn_lap(i_btn_lap), .i_btn_clr(i_btn_clr),
    .o_pls_1k(o_pls_1k), .o_bcd8d(o_bcd8d),
    .o_running(o_running), .o_lap(o_lap), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] to_bcd(input int unsigned cs);
    int unsigned h, m, s, c;
    h = cs / 360000; m = (cs / 6000) % 60; s = (cs / 100) % 60; c = cs % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int unsigned cs_now();
    return (m_ms / 10) % DAY;
  endfunction

  function automatic logic [31:0] exp_disp();
    return (m_st == 2) ? to_bcd(m_snap) : to_bcd(cs_now());
  endfunction

  function automatic bit exp_run();
    return (m_st == 1) || (m_st == 2);
  endfunction

  task automatic model_init();
    m_st = 0; m_ms = 0; m_snap = 0; m_cyc = 0;
    m_pss = 0; m_plap = 0; m_pclr = 0; e_pls = 0; e_ovf = 0;
  endtask

  // One clock: drive levels for the next edge, advance the model, land on the negedge.
  task automatic step(input bit ss, input bit lap, input bit clr);
    bit inc, es, el, ec;
    int unsigned old_cs;
    old_cs = cs_now();
    inc = e_pls && exp_run();
    if (inc) m_ms++;
    e_ovf = inc && (m_ms % 10 == 0) && (((m_ms / 10) % DAY) == 0);
    es = ss && !m_pss; el = lap && !m_plap; ec = clr && !m_pclr;
    m_pss = ss; m_plap = lap; m_pclr = clr;
    case (m_st)
      0: if (es) begin m_st = 1; m_ms = 0; end
      1: if (es) m_st = 3; else if (el) begin m_st = 2; m_snap = old_cs; end
      2: if (es) m_st = 3; else if (el) m_st = 1;
      default: if (ec) begin m_st = 0; m_ms = 0; end else if (es) m_st = 1;
    endcase
    i_btn_ss = ss; i_btn_lap = lap; i_btn_clr = clr;
    m_cyc++;
    e_pls = (m_cyc % PLS_DIV == 0);
    @(negedge i_clk);
  endtask

  task automatic run_until(input int unsigned cs, input int budget, output bit ok);
    int n;
    n = 0;
    while (cs_now() != cs && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    ok = (cs_now() == cs);
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    #23;
    n_chk++;
    if ({o_bcd8d, o_running, o_lap, o_ovf, o_pls_1k} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", {o_bcd8d, o_running, o_lap, o_ovf, o_pls_1k});
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    model_init();
    for (int i = 0; i < 35; i++) begin
      step(0, 0, 0);
      n_chk++;
      if (o_pls_1k !== e_pls) begin
        n_fail++; $display("FAIL strobe cycle %0d got %b exp %b", m_cyc, o_pls_1k, e_pls);
      end
    end
    n_chk++;
    if (o_bcd8d !== 32'h0 || o_running !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got %h/%b exp 0/0", o_bcd8d, o_running);
    end
  endtask

  task automatic test_start_count();
    bit ok;
    for (int i = 0; i < 50; i++) step(1, 0, 0);
    n_chk++;
    if (o_running !== 1'b1 || o_lap !== 1'b0) begin
      n_fail++; $display("FAIL start_held got run=%b lap=%b exp 1/0", o_running, o_lap);
    end
    run_until(10, 1200, ok);
    n_chk++;
    if (!ok || o_bcd8d !== 32'h0000_0010) begin
      n_fail++; $display("FAIL start_100_strobes got %h exp %h", o_bcd8d, 32'h0000_0010);
    end
  endtask

  task automatic test_pause_resume_clear();
    bit ok;
    run_until(37, 3000, ok);
    for (int i = 0; i < int'($urandom_range(0, 90)); i++) step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    n_chk++;
    if (o_running !== 1'b0) begin
      n_fail++; $display("FAIL pause_running got %b exp 0", o_running);
    end
    for (int i = 0; i < 300; i++) step(0, 0, 0);
    n_chk++;
    if (!ok || o_bcd8d !== 32'h0000_0037) begin
      n_fail++; $display("FAIL pause_hold got %h exp %h", o_bcd8d, 32'h0000_0037);
    end
    step(1, 0, 0);
    for (int i = 0; i < 120; i++) begin
      step(0, 0, 0);
      n_chk++;
      if (o_bcd8d !== exp_disp()) begin
        n_fail++; $display("FAIL resume_phase got %h exp %h", o_bcd8d, exp_disp());
      end
    end
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    n_chk++;
    if (o_bcd8d !== 32'h0 || o_running !== 1'b0) begin
      n_fail++; $display("FAIL clear got %h/%b exp 0/0", o_bcd8d, o_running);
    end
  endtask

  task automatic test_lap();
    bit ok;
    step(1, 0, 0); step(0, 0, 0);
    run_until(125, 13000, ok);
    step(0, 1, 0); step(0, 0, 0);
    for (int i = 0; i < 2000; i++) step(0, 0, 0);
    n_chk++;
    if (!ok || o_bcd8d !== 32'h0000_0125 || o_lap !== 1'b1) begin
      n_fail++; $display("FAIL lap_frozen got %h/%b exp %h/1", o_bcd8d, o_lap, 32'h0000_0125);
    end
    step(0, 1, 0); step(0, 0, 0);
    n_chk++;
    if (o_bcd8d !== 32'h0000_0145 || o_bcd8d !== exp_disp() || o_lap !== 1'b0) begin
      n_fail++; $display("FAIL lap_release got %h/%b exp %h/0", o_bcd8d, o_lap, 32'h0000_0145);
    end
    step(1, 0, 0); step(0, 0, 0);
    n_chk++;
    if (o_running !== 1'b0 || o_lap !== 1'b0) begin
      n_fail++; $display("FAIL lap_pause got %b/%b exp 0/0", o_running, o_lap);
    end
  endtask

  task automatic load_paused(input logic [31:0] bcd, input int unsigned cs);
    force dut.r_cnt = bcd;
    m_ms = cs * 10 + (m_ms % 10);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    release dut.r_cnt;
    step(0, 0, 0);
  endtask

  task automatic test_carry_wrap();
    bit ok;
    int ovf_seen;
    load_paused(32'h0059_5999, 359999);
    step(1, 0, 0); step(0, 0, 0);
    run_until(360000, 150, ok);
    n_chk++;
    if (!ok || o_bcd8d !== 32'h0100_0000) begin
      n_fail++; $display("FAIL carry_hour got %h exp %h", o_bcd8d, 32'h0100_0000);
    end
    step(1, 0, 0); step(0, 0, 0);
    load_paused(32'h2359_5999, 8639999);
    step(1, 0, 0);
    ovf_seen = 0;
    for (int i = 0; i < 150 && !e_ovf; i++) begin
      step(0, 0, 0);
      if (o_ovf === 1'b1) ovf_seen++;
    end
    n_chk++;
    if (!e_ovf || o_bcd8d !== 32'h0 || o_ovf !== 1'b1) begin
      n_fail++; $display("FAIL wrap got %h ovf=%b exp 0 ovf=1", o_bcd8d, o_ovf);
    end
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0);
      if (o_ovf === 1'b1) ovf_seen++;
    end
    n_chk++;
    if (ovf_seen != 1) begin
      n_fail++; $display("FAIL ovf_width got %0d cycles exp 1", ovf_seen);
    end
  endtask

  task automatic test_simultaneous();
    step(1, 1, 0); step(0, 0, 0);
    n_chk++;
    if (o_running !== 1'b0 || o_lap !== 1'b0 || o_bcd8d !== exp_disp()) begin
      n_fail++; $display("FAIL ss_lap_run got run=%b lap=%b exp 0/0", o_running, o_lap);
    end
    step(1, 0, 1); step(0, 0, 0);
    n_chk++;
    if (o_running !== 1'b0 || o_bcd8d !== 32'h0) begin
      n_fail++; $display("FAIL clr_ss_pause got %h/%b exp 0/0", o_bcd8d, o_running);
    end
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    n_chk++;
    if (o_running !== 1'b1) begin
      n_fail++; $display("FAIL clr_in_run got run=%b exp 1", o_running);
    end
  endtask

  task automatic test_random();
    bit ss, lap, clr;
    int hold;
    for (int it = 0; it < 60; it++) begin
      ss  = ($urandom_range(0, 3) == 0);
      lap = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 4) == 0);
      hold = int'($urandom_range(1, 80));
      for (int c = 0; c < hold; c++) begin
        step(ss, lap, clr);
        n_chk++;
        if (o_bcd8d !== exp_disp() || o_running !== exp_run() || o_lap !== (m_st == 2)) begin
          n_fail++; $display("FAIL random it %0d got %h/%b/%b exp %h/%b/%b", it, o_bcd8d,
                             o_running, o_lap, exp_disp(), exp_run(), (m_st == 2));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    step(0, 0, 0);
    if (!exp_run()) begin
      step(0, 0, 1); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
      if (!exp_run()) begin step(1, 0, 0); step(0, 0, 0); end
    end
    for (int i = 0; i < 150; i++) step(0, 0, 0);
    n_chk++;
    if (o_running !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_run got %b exp 1", o_running);
    end
    #2 i_rstn = 1'b0;
    #1;
    n_chk++;
    if ({o_bcd8d, o_running, o_lap, o_ovf, o_pls_1k} !== 36'h0) begin
      n_fail++; $display("FAIL async_reset got %h exp 0", {o_bcd8d, o_running, o_lap, o_ovf, o_pls_1k});
    end
    i_btn_ss = 1'b0; i_btn_lap = 1'b0; i_btn_clr = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    model_init();
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    n_chk++;
    if (o_bcd8d !== 32'h0 || o_running !== 1'b0 || o_pls_1k !== e_pls) begin
      n_fail++; $display("FAIL post_reset got %h/%b/%b exp 0/0/%b", o_bcd8d, o_running, o_pls_1k, e_pls);
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_pause_resume_clear();
    test_lap();
    test_carry_wrap();
    test_simultaneous();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
